// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg: shared types and helpers for the PLL bring-up supervisor.
//   state_t       - sequencer states
//   LOCK_LOSS_MAX - saturation value of the lock-loss event counter
//   sat_inc8      - saturating 8-bit increment
//   max3          - elaboration-time maximum of three integers (counter sizing)
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [7:0] LOCK_LOSS_MAX = 8'd255;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == LOCK_LOSS_MAX) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

endpackage

// File: rtl/pll_supervisor_if.sv
// pll_supervisor_if: PLL-side and system-side signals of the supervisor.
//   locked, restart               - driven by the environment (PLL LOCK, restart request)
//   pll_reset, system_reset_n,
//   ready, fault, retry_count,
//   lock_loss_count               - driven by the supervisor
// Modports: master = environment side, slave = supervisor side.
interface pll_supervisor_if #(
  parameter int MAX_RETRIES = 3
);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  logic          locked;
  logic          restart;
  logic          pll_reset;
  logic          system_reset_n;
  logic          ready;
  logic          fault;
  logic [RW-1:0] retry_count;
  logic [7:0]    lock_loss_count;

  modport master (
    output locked, restart,
    input  pll_reset, system_reset_n, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    input  locked, restart,
    output pll_reset, system_reset_n, ready, fault, retry_count, lock_loss_count
  );

endinterface

// File: rtl/pll_supervisor_sync.sv
// pll_supervisor_sync: two-flop single-bit synchronizer, async active-low reset to 0.
//   clock   - destination clock
//   reset_n - asynchronous active-low reset
//   d       - asynchronous input bit
//   q       - synchronized output (two-cycle latency)
module pll_supervisor_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the first stage may go metastable and gets a full cycle to settle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor: sequences ECP5 PLL bring-up on the reference clock.
//   clock   - PLL reference clock
//   reset_n - asynchronous active-low reset
//   bus     - slave side of pll_supervisor_if (locked/restart in; pll_reset,
//             system_reset_n, ready, fault, retry_count, lock_loss_count out)
// Holds the PLL in reset, waits for lock with a timeout, demands a run of stable
// lock before releasing system reset, retries on failure and faults after
// MAX_RETRIES failed attempts. All outputs come straight from flops.
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3
) (
  input logic             clock,
  input logic             reset_n,
  pll_supervisor_if.slave bus
);

  localparam int CW = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RESET_CYCLES));
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RT_MAX  = RW'(MAX_RETRIES);

  logic          locked_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_reset_q, pll_reset_d;
  logic          sys_rst_n_q, sys_rst_n_d;
  logic          ready_q, ready_d;
  logic          fault_q, fault_d;

  pll_supervisor_sync u_lock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (bus.locked),
    .q       (locked_s)
  );

  // Next-state, counter and event-count logic; restart overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    if (bus.restart) begin
      state_d = RESET_PLL;
      cnt_d   = CW'(0);
      retry_d = RW'(0);
    end else begin
      case (state_q)
        RESET_PLL: begin
          if (cnt_q == RC_LAST) begin
            state_d = WAIT_LOCK;
            cnt_d   = CW'(0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_LOCK: begin
          // Lock seen on the timeout cycle still counts as a success.
          if (locked_s) begin
            state_d = STABLE;
            cnt_d   = CW'(0);
          end else if (cnt_q == LT_LAST) begin
            retry_d = retry_q + RW'(1);
            cnt_d   = CW'(0);
            if (retry_d == RT_MAX) begin
              state_d = FAULT;
            end else begin
              state_d = RESET_PLL;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE: begin
          // A dropout here is treated as a glitch: back to waiting, no retry charged.
          if (!locked_s) begin
            state_d = WAIT_LOCK;
            cnt_d   = CW'(0);
          end else if (cnt_q == SC_LAST) begin
            state_d = RUN;
            cnt_d   = CW'(0);
            retry_d = RW'(0);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_d = RESET_PLL;
            cnt_d   = CW'(0);
            loss_d  = sat_inc8(loss_q);
          end else begin
            state_d = RUN;
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
        default: begin
          state_d = RESET_PLL;
          cnt_d   = CW'(0);
        end
      endcase
    end
  end

  // Output decode from the next state so the flopped outputs track the state register.
  always_comb begin
    pll_reset_d = (state_d == RESET_PLL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    fault_d     = (state_d == FAULT);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_PLL;
      cnt_q       <= CW'(0);
      retry_q     <= RW'(0);
      loss_q      <= 8'd0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      pll_reset_q <= pll_reset_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.pll_reset       = pll_reset_q;
  assign bus.system_reset_n  = sys_rst_n_q;
  assign bus.ready           = ready_q;
  assign bus.fault           = fault_q;
  assign bus.retry_count     = retry_q;
  assign bus.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: randomized + directed bench with a scoreboard queue.
// Stimulus pushes the expected post-edge outputs from a timer-based reference
// model; a negedge monitor pops and compares against the DUT.
module tb_pll_supervisor;

  localparam int RC = 4;
  localparam int LT = 32;
  localparam int SC = 8;
  localparam int MR = 2;

  logic clock = 1'b0;
  logic reset_n;

  pll_supervisor_if #(.MAX_RETRIES(MR)) bus ();

  pll_supervisor #(
    .RESET_CYCLES (RC),
    .LOCK_TIMEOUT (LT),
    .STABLE_CYCLES(SC),
    .MAX_RETRIES  (MR)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef enum int {M_RST, M_WAIT, M_STAB, M_RUN, M_FAULT} mphase_t;
  typedef struct {
    int pll_reset;
    int sys_n;
    int ready;
    int fault;
    int retry;
    int loss;
  } exp_t;

  exp_t    exp_q[$];
  int      checks = 0;
  int      failures = 0;

  // Reference model: phase plus a countdown of cycles left in that phase.
  mphase_t m_ph;
  int      m_left;
  int      m_retries;
  int      m_losses;
  int      m_s1;
  int      m_s2;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = M_RST; m_left = RC; m_retries = 0; m_losses = 0; m_s1 = 0; m_s2 = 0;
  endtask

  // Advance the model by one clock edge with the given inputs and queue the expected outputs.
  task automatic model_step(input logic lk, input logic rs);
    int   ls;
    exp_t e;
    ls   = m_s2;
    m_s2 = m_s1;
    m_s1 = int'(lk);
    if (rs) begin
      m_ph = M_RST; m_left = RC; m_retries = 0;
    end else begin
      case (m_ph)
        M_RST: begin
          m_left--;
          if (m_left == 0) begin m_ph = M_WAIT; m_left = LT; end
        end
        M_WAIT: begin
          if (ls != 0) begin
            m_ph = M_STAB; m_left = SC;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_retries++;
              if (m_retries == MR) m_ph = M_FAULT;
              else begin m_ph = M_RST; m_left = RC; end
            end
          end
        end
        M_STAB: begin
          if (ls == 0) begin
            m_ph = M_WAIT; m_left = LT;
          end else begin
            m_left--;
            if (m_left == 0) begin m_ph = M_RUN; m_retries = 0; end
          end
        end
        M_RUN: begin
          if (ls == 0) begin
            m_ph = M_RST; m_left = RC;
            if (m_losses < 255) m_losses++;
          end
        end
        default: ;
      endcase
    end
    e.pll_reset = (m_ph == M_RST) ? 1 : 0;
    e.sys_n     = (m_ph == M_RUN) ? 1 : 0;
    e.ready     = (m_ph == M_RUN) ? 1 : 0;
    e.fault     = (m_ph == M_FAULT) ? 1 : 0;
    e.retry     = m_retries;
    e.loss      = m_losses;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic lk, input logic rs);
    @(negedge clock);
    #1;
    bus.locked  = lk;
    bus.restart = rs;
    model_step(lk, rs);
  endtask

  // Lock pulse that starts and ends between two rising edges, so it is never sampled.
  task automatic glitch_cycle();
    @(negedge clock);
    #1;
    bus.restart = 1'b0;
    bus.locked  = 1'b1;
    #2;
    bus.locked  = 1'b0;
    model_step(1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pll_reset"}, int'(bus.pll_reset), 1);
    check({tag, "_sys_rst_n"}, int'(bus.system_reset_n), 0);
    check({tag, "_ready"}, int'(bus.ready), 0);
    check({tag, "_fault"}, int'(bus.fault), 0);
    check({tag, "_retry"}, int'(bus.retry_count), 0);
    check({tag, "_loss"}, int'(bus.lock_loss_count), 0);
  endtask

  // Assert reset_n between edges, check the immediate effect, then release cleanly.
  task automatic async_reset_mid(input string tag);
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    model_step(1'b0, 1'b0);
  endtask

  // Scoreboard monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pll_reset", int'(bus.pll_reset), e.pll_reset);
      check("system_reset_n", int'(bus.system_reset_n), e.sys_n);
      check("ready", int'(bus.ready), e.ready);
      check("fault", int'(bus.fault), e.fault);
      check("retry_count", int'(bus.retry_count), e.retry);
      check("lock_loss_count", int'(bus.lock_loss_count), e.loss);
    end
  end

  initial begin
    logic lk;
    int   len;
    int   hit;
    logic rs;

    reset_n     = 1'b0;
    bus.locked  = 1'b0;
    bus.restart = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    check_reset_outputs("por");
    #1;
    reset_n = 1'b1;
    model_step(1'b0, 1'b0);

    // 1: lock arrives after 10 cycles and stays.
    repeat (9) cycle(1'b0, 1'b0);
    repeat (30) cycle(1'b1, 1'b0);

    // 2: lock never arrives -> two attempts then fault; restart recovers.
    repeat (5) cycle(1'b0, 1'b0);
    repeat (2 * (RC + LT) + 10) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (10) cycle(1'b0, 1'b0);

    // 3: drop lock for 3 cycles at stable count 5.
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      if (m_ph == M_STAB && m_left == SC - 5) begin
        hit = 1;
        break;
      end
      cycle(1'b1, 1'b0);
    end
    check("reach_stable5", hit, 1);
    repeat (3) cycle(1'b0, 1'b0);
    repeat (20) cycle(1'b1, 1'b0);

    // 4: repeated lock loss from RUN, saturating the loss counter.
    for (int i = 0; i < 258; i++) begin
      repeat (20) cycle(1'b1, 1'b0);
      repeat (3) cycle(1'b0, 1'b0);
    end

    // 5: asynchronous reset mid-WAIT_LOCK and mid-RUN.
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      if (m_ph == M_WAIT && m_left < LT - 4) break;
      cycle(1'b0, 1'b0);
    end
    async_reset_mid("rst_wait");
    repeat (30) cycle(1'b1, 1'b0);
    async_reset_mid("rst_run");

    // 6: sub-sample lock glitch in WAIT_LOCK, then restart on the timeout edge.
    repeat (6) cycle(1'b0, 1'b0);
    glitch_cycle();
    hit = 0;
    for (int i = 0; i < 100; i++) begin
      rs = (m_ph == M_WAIT && m_left == 1) ? 1'b1 : 1'b0;
      cycle(1'b0, rs);
      if (rs) begin
        hit = 1;
        break;
      end
    end
    check("restart_on_timeout", hit, 1);
    repeat (10) cycle(1'b0, 1'b0);

    // Random lock runs with occasional restarts and glitches.
    for (int i = 0; i < 60; i++) begin
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 50);
      for (int j = 0; j < len; j++) begin
        if (!lk && $urandom_range(0, 15) == 0) glitch_cycle();
        else cycle(lk, ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
      end
    end

    @(negedge clock);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
Sequences bring-up of the ECP5 PLL and owns its RST input. Holds the PLL in reset, waits for LOCK with a timeout, and requires lock to stay stable before releasing a system reset. It re-runs the sequence on lock loss and declares a fault after repeated lock failures. Runs on the PLL reference clock, because the PLL output is not trustworthy until locked.

Parameters:
RESET_CYCLES, 16, cycles pll_reset is held high per attempt (>=1)
LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before the attempt fails (>=2)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
MAX_RETRIES, 3, failed attempts before FAULT (>=1)

Ports:
clock  input  1  PLL reference clock; all logic in this domain
reset_n  input  1  asynchronous, active-low reset
locked  input  1  PLL LOCK; asynchronous to clock, double-flop synchronized internally
restart  input  1  synchronous one-cycle request to restart sequencing from any state
pll_reset  output  1  drives PLL RST, active high
system_reset_n  output  1  active-low reset for downstream logic; low until stable lock
ready  output  1  high exactly while in RUN
fault  output  1  high exactly while in FAULT
retry_count  output  $clog2(MAX_RETRIES+1)  failed attempts since last RUN/restart
lock_loss_count  output  8  count of RUN->lock-lost events, saturates at 255

Behaviour:
- Reset (reset_n low, asynchronous): state=RESET_PLL, counter=0, pll_reset=1, system_reset_n=0, ready=0, fault=0, retry_count=0, lock_loss_count=0, sync flops=0.
- locked_s = locked after two flops. 2-cycle latency; all decisions use locked_s only.
- All outputs are registered or decoded directly from the state register. No combinational path from inputs to outputs.
- RESET_PLL: pll_reset=1. The counter runs 0..RESET_CYCLES-1, then the state goes to WAIT_LOCK with counter=0. The total time with pll_reset high is exactly RESET_CYCLES cycles.
- WAIT_LOCK: pll_reset=0, counter increments.
  - locked_s=1 -> STABLE, counter=0.
  - Otherwise, when counter reaches LOCK_TIMEOUT-1: retry_count+1. If the new value equals MAX_RETRIES -> FAULT, else -> RESET_PLL.
  - If locked_s rises on the timeout cycle, the lock wins.
- STABLE: counter increments while locked_s=1.
  - locked_s=0 -> WAIT_LOCK, counter=0. This is a glitch: no retry charged, timeout restarts.
  - Counter reaches STABLE_CYCLES-1 with locked_s=1 -> RUN, retry_count=0.
- RUN: system_reset_n=1, ready=1.
  - locked_s=0 -> RESET_PLL, lock_loss_count+1 (saturating).
  - system_reset_n returns to 0 on the same edge the state leaves RUN.
- FAULT: pll_reset=0, system_reset_n=0, fault=1. The state holds until restart or reset_n.
- restart=1 in any state (it has priority over all other transitions) -> RESET_PLL, counter=0, retry_count=0. lock_loss_count is not cleared.
- system_reset_n is asserted asynchronously only by reset_n; otherwise it changes on clock edges. Downstream domains re-synchronize its deassertion.
- Counter width is $clog2 of the max of LOCK_TIMEOUT, STABLE_CYCLES and RESET_CYCLES; no wrap is reachable.

Decomposition:
- pll_supervisor_pkg: state_t enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT}, LOCK_LOSS_MAX=8'd255.
- Sub-module synchronizer: a 2-flop bit synchronizer with async active-low reset to 0, reusable for other CDC bits.
- FSM and counters stay in pll_supervisor.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release reset_n; assert locked 10 cycles later and hold it -> pll_reset high exactly 4 cycles; ready=1 and system_reset_n=1 exactly 2+8 cycles after locked rises (+1 registering edge); retry_count=0.
2. Never assert locked -> two pll_reset pulses of 4 cycles each, 32 cycles apart; then fault=1, retry_count=2, pll_reset=0 held. Pulse restart -> retry_count=0, new 4-cycle pll_reset pulse.
3. In STABLE, drop locked for 3 cycles at stable count 5, then reassert -> no pll_reset pulse, retry_count unchanged, ready only after 8 further consecutive locked_s cycles.
4. In RUN, drop locked -> 2 cycles later system_reset_n=0, ready=0, lock_loss_count=1, pll_reset pulse of 4; repeat 256 times -> lock_loss_count saturates at 255.
5. Assert reset_n low mid-WAIT_LOCK and mid-RUN, asynchronously between edges -> pll_reset=1 and system_reset_n=0 immediately, counts cleared.
6. Single-cycle 1-cycle locked glitch in WAIT_LOCK shorter than the sync window, plus restart coinciding with timeout -> restart wins: RESET_PLL, retry_count=0.
